fetch_prefetch_queue: RTL and testbench

Instruction fetch front end that sits directly upstream of the single-cycle core's decode/execute path.
- Issues sequential 32-bit instruction reads to a multi-cycle instruction memory.
- Buffers returned words with their PCs in a small FIFO.
- Presents them to the core over a valid/ready handshake.
- Supports a one-cycle redirect (taken branch/jump) that flushes the queue and discards in-flight stale responses.

---
 rtl/fetch_prefetch_queue_if.sv | 51 +++++
 rtl/fetch_prefetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: restart control, memory
// request/response channel and instruction delivery.
interface fetch_prefetch_queue_if #(
  parameter int CNT_W = 3
);
  logic [63:0]      startpc;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [63:0]      mem_req_addr;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst_data;
  logic [63:0]      inst_pc;
  logic [CNT_W-1:0] occupancy;

  modport master (
    input  startpc,
    input  redirect_valid,
    input  redirect_pc,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  inst_ready,
    output mem_req_valid,
    output mem_req_addr,
    output inst_valid,
    output inst_data,
    output inst_pc,
    output occupancy
  );

  modport slave (
    output startpc,
    output redirect_valid,
    output redirect_pc,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    output inst_ready,
    input  mem_req_valid,
    input  mem_req_addr,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    input  occupancy
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited
// issue, a small PC/word FIFO and redirect flush.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic                   CLK,
  input logic                   resetl,
  fetch_prefetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t           q_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      resp_pc_q, resp_pc_d;

  logic [CNT_W:0]   budget;
  logic             req_fire;
  logic             resp_v;
  logic             push;
  logic             pop;
  logic             have;

  // Queued words plus outstanding reads may never
  // exceed the queue size, so a push always has room.
  assign budget = {1'b0, count_q} + {1'b0, infl_q};
  assign resp_v = bus.mem_resp_valid;
  assign have   = (count_q != '0);

  assign bus.mem_req_valid = resetl
                           & ~bus.redirect_valid
                           & (budget < LIMIT);
  assign bus.mem_req_addr  = fetch_pc_q;
  assign req_fire = bus.mem_req_valid
                  & bus.mem_req_ready;

  assign bus.inst_valid = have;
  assign bus.inst_data  = have ? q_q[head_q].data : '0;
  assign bus.inst_pc    = have ? q_q[head_q].pc   : '0;
  assign bus.occupancy  = count_q;

  // Next-state for pointers, counters and fetch PCs.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    infl_d     = infl_q;
    stale_d    = stale_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~64'd3;
      resp_pc_d  = bus.redirect_pc & ~64'd3;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      infl_d     = infl_q - CNT_W'(resp_v);
      stale_d    = infl_q - CNT_W'(resp_v);
    end else begin
      pop  = have & bus.inst_ready;
      push = resp_v & (stale_q == '0);
      if (req_fire)
        fetch_pc_d = fetch_pc_q + 64'd4;
      if (resp_v && stale_q != '0)
        stale_d = stale_q - CNT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 64'd4;
        tail_d    = tail_q + PTR_W'(1);
      end
      if (pop)
        head_d = head_q + PTR_W'(1);
      infl_d  = infl_q + CNT_W'(req_fire)
              - CNT_W'(resp_v);
      count_d = count_q + CNT_W'(push)
              - CNT_W'(pop);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      infl_q     <= '0;
      stale_q    <= '0;
      fetch_pc_q <= bus.startpc;
      resp_pc_q  <= bus.startpc;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      infl_q     <= infl_d;
      stale_q    <= stale_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  // Entry storage; contents are only seen while counted.
  always_ff @(posedge CLK) begin
    if (resetl && push)
      q_q[tail_q] <= '{pc: resp_pc_q,
                       data: bus.mem_resp_data};
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bus error.
  always_ff @(posedge CLK) begin
    if (resetl && resp_v)
      assert (infl_q != '0)
      else $error("unsolicited mem response");
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed table,
// hand sequences and random traffic vs a queue model.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic CLK = 1'b0;
  logic resetl = 1'b0;

  fetch_prefetch_queue_if #(.CNT_W(CNT_W)) bus ();

  fetch_prefetch_queue #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .resetl(resetl),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] memw(
    input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%h exp=%h",
                  nm, act, exp);
  endtask

  // Model: queued words, and outstanding reads with
  // their address, due cycle and stale mark.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } req_t;

  ent_t        mq[$];
  req_t        mo[$];
  logic [63:0] m_fpc;
  int          cyc = 0;
  int          lat = 1;

  task automatic step(input bit rn, input bit rd,
                      input logic [63:0] rpc,
                      input bit rdy, input bit ird);
    bit   rv;
    bit   ev;
    bit   pop;
    req_t r;
    @(negedge CLK);
    rv = rn && mo.size() > 0 && mo[0].due <= cyc;
    resetl             = rn;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.mem_req_ready  = rdy;
    bus.inst_ready     = ird;
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = rv ? memw(mo[0].addr) : '0;
    #1;
    ev = rn && !rd && (mq.size() + mo.size() < DEPTH);
    chk("req_valid", bus.mem_req_valid, ev);
    if (!rn) begin
      mq.delete();
      mo.delete();
      m_fpc = bus.startpc;
    end else begin
      chk("inst_valid", bus.inst_valid, mq.size() != 0);
      chk("occupancy", bus.occupancy, mq.size());
      chk("inst_pc", bus.inst_pc,
          mq.size() != 0 ? mq[0].pc : 64'h0);
      chk("inst_data", bus.inst_data,
          mq.size() != 0 ? {32'h0, mq[0].data} : 64'h0);
      if (ev) chk("req_addr", bus.mem_req_addr, m_fpc);
      if (rd) begin
        if (rv) r = mo.pop_front();
        foreach (mo[i]) mo[i].stale = 1'b1;
        mq.delete();
        m_fpc = rpc & ~64'd3;
      end else begin
        pop = mq.size() != 0 && ird;
        if (pop) void'(mq.pop_front());
        if (rv) begin
          r = mo.pop_front();
          if (!r.stale)
            mq.push_back('{r.addr, memw(r.addr)});
        end
        if (ev && rdy) begin
          mo.push_back('{m_fpc, cyc + lat, 1'b0});
          m_fpc += 64'd4;
        end
      end
    end
    cyc++;
  endtask

  typedef struct {
    bit          rn, rd;
    logic [63:0] rpc;
    bit          rdy, ird, rv;
    logic [63:0] raddr;
    bit          ev;
    logic [63:0] eaddr;
    bit          eiv;
    logic [63:0] epc;
    int          eocc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    bit rn, bit rd, logic [63:0] rpc, bit rdy,
    bit ird, bit rv, logic [63:0] raddr, bit ev,
    logic [63:0] eaddr, bit eiv, logic [63:0] epc,
    int eocc);
    vec_t t;
    t = '{rn, rd, rpc, rdy, ird, rv, raddr,
          ev, eaddr, eiv, epc, eocc};
    return t;
  endfunction

  logic [63:0] a0;
  bit          found;

  initial begin
    bus.startpc        = 64'h1000;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.inst_ready     = 1'b0;

    // Fill to the credit limit, drain, then redirect.
    tbl.push_back(v(0,0,0,1,0,0,0, 0,0,      0,0,0));
    tbl.push_back(v(1,0,0,1,0,0,0, 1,'h1000, 0,0,0));
    tbl.push_back(v(1,0,0,1,0,1,'h1000,
                    1,'h1004, 0,0,0));
    tbl.push_back(v(1,0,0,1,0,1,'h1004,
                    1,'h1008, 1,'h1000,1));
    tbl.push_back(v(1,0,0,1,0,1,'h1008,
                    1,'h100c, 1,'h1000,2));
    tbl.push_back(v(1,0,0,1,0,1,'h100c,
                    0,0, 1,'h1000,3));
    tbl.push_back(v(1,0,0,1,0,0,0, 0,0, 1,'h1000,4));
    tbl.push_back(v(1,0,0,1,0,0,0, 0,0, 1,'h1000,4));
    tbl.push_back(v(1,0,0,1,1,0,0, 0,0, 1,'h1000,4));
    tbl.push_back(v(1,0,0,1,1,0,0,
                    1,'h1010, 1,'h1004,3));
    tbl.push_back(v(1,0,0,1,0,1,'h1010,
                    1,'h1014, 1,'h1008,2));
    tbl.push_back(v(1,0,0,0,0,1,'h1014,
                    0,0, 1,'h1008,3));
    tbl.push_back(v(1,0,0,1,1,0,0, 0,0, 1,'h1008,4));
    tbl.push_back(v(1,1,'h2003,1,1,0,0,
                    0,0, 1,'h100c,3));
    tbl.push_back(v(1,0,0,1,1,0,0, 1,'h2000, 0,0,0));
    tbl.push_back(v(1,0,0,1,1,1,'h2000,
                    1,'h2004, 0,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0,
                    1,'h2008, 1,'h2000,1));

    foreach (tbl[i]) begin
      @(negedge CLK);
      resetl             = tbl[i].rn;
      bus.redirect_valid = tbl[i].rd;
      bus.redirect_pc    = tbl[i].rpc;
      bus.mem_req_ready  = tbl[i].rdy;
      bus.inst_ready     = tbl[i].ird;
      bus.mem_resp_valid = tbl[i].rv;
      bus.mem_resp_data  = tbl[i].rv ?
                           memw(tbl[i].raddr) : '0;
      #1;
      chk("t_req_valid", bus.mem_req_valid, tbl[i].ev);
      if (tbl[i].rn) begin
        if (tbl[i].ev)
          chk("t_req_addr", bus.mem_req_addr,
              tbl[i].eaddr);
        chk("t_inst_valid", bus.inst_valid, tbl[i].eiv);
        chk("t_occ", bus.occupancy, tbl[i].eocc);
        chk("t_inst_pc", bus.inst_pc,
            tbl[i].eiv ? tbl[i].epc : 64'h0);
        chk("t_inst_data", bus.inst_data,
            tbl[i].eiv ? {32'h0, memw(tbl[i].epc)}
                       : 64'h0);
      end
    end

    // Streaming: one word per cycle once filled.
    lat = 1;
    bus.startpc = 64'h1000;
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 1, 1);
      chk("s_valid", bus.inst_valid, 1'b1);
      chk("s_pc", bus.inst_pc, 64'h1000 + 64'(4 * k));
    end

    // Redirect with response and pop, three in flight.
    lat = 3;
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 0);
    step(1, 1, 64'h3000_0001, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("r_flush_valid", bus.inst_valid, 1'b0);
    chk("r_flush_occ", bus.occupancy, 0);
    chk("r_first_req", bus.mem_req_addr, 64'h3000_0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0, 1, 1);
      if (bus.inst_valid) begin
        found = 1'b1;
        chk("r_first_pc", bus.inst_pc, 64'h3000_0000);
      end
    end
    if (!found) chk("r_timeout", 0, 1);

    // Request held while memory stalls.
    lat = 2;
    bus.startpc = 64'h5000;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    a0 = bus.mem_req_addr;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 1);
      chk("h_addr", bus.mem_req_addr, 64'h5000);
      chk("h_valid", bus.mem_req_valid, 1'b1);
    end
    chk("h_addr0", a0, 64'h5000);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("h_next", bus.mem_req_addr, 64'h5004);

    // Reset with words queued and reads in flight.
    lat = 3;
    bus.startpc = 64'h1000;
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1, 0);
    chk("x_occ_before", bus.occupancy, 2);
    bus.startpc = 64'h4000;
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("x_valid", bus.inst_valid, 1'b0);
    chk("x_occ", bus.occupancy, 0);
    chk("x_req_v", bus.mem_req_valid, 1'b1);
    chk("x_req_a", bus.mem_req_addr, 64'h4000);

    // Random traffic against the model.
    for (int b = 0; b < 6; b++) begin
      lat = $urandom_range(1, 4);
      bus.startpc = {$urandom, $urandom} & ~64'd3;
      step(0, 0, 0, 1, 0);
      for (int k = 0; k < 500; k++) begin
        logic [63:0] rpc;
        rpc = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0)
          rpc = 64'hFFFF_FFFF_FFFF_FFF5;
        step($urandom_range(0, 199) != 0,
             $urandom_range(0, 19) == 0,
             rpc,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) > 1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
